// File: rtl/mod_pow2_mul_ctrl.sv
// Iterative modular power-of-two scaler: oData = (iData * 2^iShift) mod iMod.
// A single doubler-with-conditional-subtract is reused once per clock until the count drains.
module mod_pow2_mul_ctrl #(
  parameter int BITWIDTH = 32,
  parameter int SHIFTW   = 6
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iMod,
  input  logic [SHIFTW-1:0]   iShift,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic                oBusy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // The operand side is ready only in IDLE; the result side is valid only in DONE and
  // oData is held until the consumer takes it.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [BITWIDTH-1:0]   acc_q, acc_d;
  logic [BITWIDTH-1:0]   mod_q, mod_d;
  logic [SHIFTW-1:0]     cnt_q, cnt_d;

  // The doubled value needs one extra bit; subtracting m in the truncated domain
  // yields the same low bits, and m=0 naturally degenerates to 2x mod 2^BITWIDTH.
  function automatic logic [BITWIDTH-1:0] dbl(input logic [BITWIDTH-1:0] x,
                                               input logic [BITWIDTH-1:0] m);
    logic [BITWIDTH:0]   s;
    logic [BITWIDTH-1:0] r;
    s = {x, 1'b0};
    if (s >= {1'b0, m}) r = s[BITWIDTH-1:0] - m;
    else                r = s[BITWIDTH-1:0];
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mod_d   = mod_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          acc_d   = iData;
          mod_d   = iMod;
          cnt_d   = iShift;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q != '0) begin
          acc_d = dbl(acc_q, mod_q);
          cnt_d = cnt_q - SHIFTW'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (iReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mod_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mod_q   <= mod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oReady = (state_q == S_IDLE);
  assign oValid = (state_q == S_DONE);
  assign oBusy  = (state_q == S_RUN) || (state_q == S_DONE);
  assign oData  = acc_q;

endmodule

// File: tb/tb_mod_pow2_mul_ctrl.sv
// Bench for mod_pow2_mul_ctrl at BITWIDTH=8: hand-computed vector table, corner
// sequences (reset mid-run, back-to-back issue), and random operations vs an arithmetic model.
module tb_mod_pow2_mul_ctrl;

  localparam int W  = 8;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_data;
  logic [W-1:0]  i_mod;
  logic [SW-1:0] i_shift;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_data;
  logic          o_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc;
  int hs_cyc;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]  x;
    logic [W-1:0]  m;
    logic [SW-1:0] k;
    int            hold;
    bit            keep_valid;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t vecs[9];

  mod_pow2_mul_ctrl #(.BITWIDTH(W), .SHIFTW(SW)) dut (
    .iClk  (clk),
    .iRst  (rst),
    .iValid(i_valid),
    .oReady(o_ready),
    .iData (i_data),
    .iMod  (i_mod),
    .iShift(i_shift),
    .oValid(o_valid),
    .iReady(i_ready),
    .oData (o_data),
    .oBusy (o_busy)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: repeated doubling in plain integer arithmetic, modulus 0 meaning 2^W.
  function automatic logic [W-1:0] ref_model(input int x, input int m, input int k);
    longint r;
    longint mm;
    mm = (m == 0) ? (longint'(1) << W) : longint'(m);
    r  = x;
    for (int i = 0; i < k; i++) r = (r * 2) % mm;
    return r[W-1:0];
  endfunction

  // Driver: issue one operation, then scoreboard the result and its timing.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] m, input logic [SW-1:0] k,
                        input int hold, input bit keep_valid, input logic [W-1:0] exp);
    int n;
    int lat;
    bit got;
    bit run_ok;
    logic [W-1:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    n = 0;
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      chk("ready_timeout", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    i_valid = 1'b1;
    i_data  = x;
    i_mod   = m;
    i_shift = k;
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!keep_valid) i_valid = 1'b0;
    got    = 1'b0;
    run_ok = 1'b1;
    lat    = 0;
    while (!got && lat < 200) begin
      i_data  = W'($urandom);
      i_mod   = W'($urandom);
      i_shift = SW'($urandom);
      @(posedge clk); #1;
      lat++;
      if (o_valid) got = 1'b1;
      else if (!(o_busy && !o_ready)) run_ok = 1'b0;
    end
    chk("latency", lat, k + 1);
    if (!got) begin
      void'(exp_q.pop_front());
      i_valid = 1'b0;
      return;
    end
    chk("run_flags", run_ok, 1);
    e = exp_q.pop_front();
    chk("result", o_data, e);
    chk("done_flags", {o_busy, o_ready}, 2'b10);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {o_valid, o_ready, o_data}, {1'b1, 1'b0, e});
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    hs_cyc  = cyc;
    i_ready = 1'b0;
    i_valid = 1'b0;
    chk("valid_fall", o_valid, 0);
    chk("ready_back", {o_ready, o_busy}, 2'b10);
  endtask

  initial begin
    int a1;
    int h1;
    logic [W-1:0] rx, rm;
    logic [SW-1:0] rk;

    vecs[0] = '{x: 8'd5,   m: 8'd13,  k: 6'd3,  hold: 5, keep_valid: 1'b0, exp: 8'd1};
    vecs[1] = '{x: 8'd9,   m: 8'd13,  k: 6'd0,  hold: 3, keep_valid: 1'b1, exp: 8'd9};
    vecs[2] = '{x: 8'h81,  m: 8'd0,   k: 6'd1,  hold: 0, keep_valid: 1'b0, exp: 8'h02};
    vecs[3] = '{x: 8'd250, m: 8'd251, k: 6'd1,  hold: 1, keep_valid: 1'b0, exp: 8'd249};
    vecs[4] = '{x: 8'd5,   m: 8'd13,  k: 6'd63, hold: 0, keep_valid: 1'b0, exp: 8'd1};
    vecs[5] = '{x: 8'd1,   m: 8'd0,   k: 6'd7,  hold: 0, keep_valid: 1'b0, exp: 8'd128};
    vecs[6] = '{x: 8'd1,   m: 8'd0,   k: 6'd8,  hold: 2, keep_valid: 1'b0, exp: 8'd0};
    vecs[7] = '{x: 8'd0,   m: 8'd13,  k: 6'd5,  hold: 0, keep_valid: 1'b0, exp: 8'd0};
    vecs[8] = '{x: 8'd254, m: 8'd255, k: 6'd2,  hold: 0, keep_valid: 1'b0, exp: 8'd251};

    // Reset with a pending request: reset must win.
    rst     = 1'b1;
    i_valid = 1'b1;
    i_ready = 1'b0;
    i_data  = 8'd77;
    i_mod   = 8'd100;
    i_shift = 6'd4;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {o_ready, o_valid, o_busy, o_data}, {1'b1, 1'b0, 1'b0, 8'd0});
    @(negedge clk);
    rst     = 1'b0;
    i_valid = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].x, vecs[i].m, vecs[i].k, vecs[i].hold, vecs[i].keep_valid, vecs[i].exp);

    // Reset after two doublings discards the operation.
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 8'd5;
    i_mod   = 8'd13;
    i_shift = 6'd3;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_running", {o_valid, o_busy}, 2'b01);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_run_reset", {o_ready, o_valid, o_busy, o_data}, {1'b1, 1'b0, 1'b0, 8'd0});
    @(posedge clk); #1;
    chk("after_reset_idle", {o_ready, o_valid}, 2'b10);
    run_op(8'd3, 8'd13, 6'd2, 0, 1'b0, 8'd12);

    // Back-to-back issue.
    run_op(8'd1, 8'd13, 6'd4, 0, 1'b0, 8'd3);
    a1 = acc_cyc;
    h1 = hs_cyc;
    run_op(8'd7, 8'd13, 6'd1, 0, 1'b0, 8'd1);
    chk("b2b_after_handshake", acc_cyc > h1, 1);
    chk("b2b_issue_interval", (acc_cyc - a1) >= 7, 1);

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      rm = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      rx = (rm == 0) ? W'($urandom) : W'($urandom_range(0, int'(rm) - 1));
      rk = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(0, 63)) : SW'($urandom_range(0, 12));
      run_op(rx, rm, rk, $urandom_range(0, 3), bit'($urandom_range(0, 1)),
             ref_model(int'(rx), int'(rm), int'(rk)));
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_pow2_mul_ctrl.md
Name: mod_pow2_mul_ctrl

Overview:
- Sequencer that drives one modular-doubler + register datapath iteratively to compute oData = (iData * 2^iShift) mod iMod.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on each side.
- Serves as the scalar building block for modular shift/scale steps in the modular-arithmetic pipeline (e.g. Montgomery/NTT pre-scaling).
- One operation in flight at a time.

Parameters:
- BITWIDTH, 32, width of operand, modulus and result.
- SHIFTW, 6, width of the shift-count input (max 2^SHIFTW-1 doublings).

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  synchronous active-high reset.
- iValid  input  1  operand request valid.
- oReady  output  1  controller can accept an operand.
- iData  input  BITWIDTH  operand x; caller guarantees x < iMod when iMod != 0.
- iMod  input  BITWIDTH  modulus m; 0 means modulus 2^BITWIDTH.
- iShift  input  SHIFTW  doubling count k.
- oValid  output  1  result valid.
- iReady  input  1  consumer accepts the result.
- oData  output  BITWIDTH  result; meaningful only while oValid=1.
- oBusy  output  1  high in RUN and DONE.

Behaviour:
- Reset: iClk with iRst=1 forces:
  - state=IDLE, acc=0, cnt=0, mod_q=0.
  - oValid=0, oReady=1, oBusy=0, oData=0.
  - Reset has priority over every other event, including mid-RUN and in DONE; the in-flight operation is discarded with no output.
- States:
  - IDLE: oReady=1, oValid=0, oBusy=0.
  - RUN: oReady=0, oValid=0, oBusy=1.
  - DONE: oReady=0, oValid=1, oBusy=1.
- Accept: edge with state=IDLE and iValid=1.
  - acc<=iData, cnt<=iShift, mod_q<=iMod; state<=RUN.
  - iData, iMod and iShift are sampled only at accept; later changes are ignored.
- RUN, each edge:
  - If cnt!=0: acc<=dbl(acc, mod_q), cnt<=cnt-1.
  - If cnt==0: state<=DONE; acc is held.
- Doubling rule dbl(x,m):
  - s = {x,1'b0} as a (BITWIDTH+1)-bit value.
  - If s >= {1'b0,m}: r = s - m; else r = s.
  - The result is truncated to BITWIDTH bits.
  - For m=0 this gives (2x) mod 2^BITWIDTH.
- Latency: oValid rises exactly k+1 cycles after the accept edge.
  - k=0 gives 1 cycle.
  - k=2^SHIFTW-1 gives 2^SHIFTW cycles.
- DONE:
  - oData=acc, held stable while iReady=0 for any number of cycles.
  - Edge with iReady=1: state<=IDLE, oValid falls on the next cycle.
- Throughput:
  - oReady is low in DONE, so a new operand cannot be accepted in the same cycle the result is consumed.
  - Minimum issue interval is k+3 cycles.
- oData outside DONE: equals the internal acc (don't-care for consumers); reset value 0.
- Precondition violation (x >= m, m != 0): no protection. The result is the deterministic output of the dbl rule and the bench must not check it. This is not flagged.
- iValid while not IDLE: ignored; the producer must hold the request until oReady.

Test Plan:
- BITWIDTH=8, m=13, x=5, k=3 -> acc sequence 5,10,7,1; oValid high exactly 4 cycles after accept with oData=1.
- m=13, x=9, k=0 -> oValid 1 cycle after accept, oData=9; iValid held high in DONE is not accepted.
- m=0, x=0x81, k=1 -> oData=0x02 (mod 2^8 wrap); m=251, x=250, k=1 -> oData=249 (exercises the carry bit).
- m=13, x=5, k=3; iReady low for 5 cycles in DONE -> oValid and oData=1 stable for all 5; iMod/iData changed during RUN have no effect.
- iRst=1 asserted for one edge during RUN (after 2 doublings) -> next cycle IDLE, oReady=1, oValid=0, oData=0.
  - A new request m=13, x=3, k=2 then yields 12.
- Back-to-back: two requests (x=1, k=4, m=13 -> 3) and (x=7, k=1, m=13 -> 1) with iReady=1.
  - Second accept occurs no earlier than 1 cycle after the first result handshake; results arrive in order.
